regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single synchronous write port of the 32×32 register file among `NUM_REQ` writeback requesters (e.g. ALU, load unit, debug port). It uses round-robin arbitration with a valid/ready handshake. After reset, or on request, it also runs a clear sequence that zeroes registers 1–31 through the same port. The block sits directly in front of the register file's `Reg_Write` / `Write_Register` / `Data` inputs; read ports are untouched.

## Interface
Clock `clk`, single clock domain. Reset `rst`, asynchronous, active-high.

Parameters:
- `NUM_REQ`, 3, number of write requesters (2–8).
- `ADDR_W`, 5, register address width.
- `DATA_W`, 32, register data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_addr`  in  NUM_REQ*ADDR_W  packed destination registers; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_data`  in  NUM_REQ*DATA_W  packed write data, same packing.
- `req_ready`  out  NUM_REQ  one-hot or zero; combinational grant.
- `clear_start`  in  1  pulse that requests a register-clear sequence.
- `busy`  out  1  high while the clear sequence runs.
- `Reg_Write`  out  1  registered write enable to the register file.
- `Write_Register`  out  ADDR_W  registered write address.
- `Data`  out  DATA_W  registered write data.

## Operation
- States are CLEAR and ARB. Reset enters CLEAR with `clr_cnt`=1.
- CLEAR state:
  - Each cycle issues a write of 0 to register `clr_cnt`, then increments `clr_cnt`.
  - The write with `clr_cnt`=31 moves the FSM to ARB.
  - `req_ready`=0 throughout.
  - `clear_start` is ignored while in CLEAR; the sequence is not restarted.
- ARB state:
  - Among asserted `req_valid` bits, grant the first index at or after `rr_ptr`, scanning with wrap-around.
  - Drive `req_ready` one-hot to the granted requester.
  - A handshake occurs when `req_valid[i]` and `req_ready[i]` are both high.
  - On a handshake, capture that requester's addr/data into the output registers and set `rr_ptr` to (i+1) mod NUM_REQ.
  - With no valid requests, `req_ready`=0 and `rr_ptr` holds.
- Writes to register 0:
  - The request is still handshaked and still advances `rr_ptr`.
  - `Reg_Write` stays 0; the write is dropped.
- `clear_start` high in ARB:
  - `req_ready`=0 that cycle, so no grant is made.
  - Next state is CLEAR with `clr_cnt`=1.
- Requester obligations: a requester holds `req_addr` and `req_data` stable while valid and not ready. `req_ready` may depend combinationally on `req_valid`; `req_valid` must not depend on `req_ready`.
- `busy` = (state == CLEAR).

## Timing
- Reset values:
  - `Reg_Write`=0, `Write_Register`=0, `Data`=0.
  - `busy`=1, `req_ready`=0.
  - `rr_ptr`=0, `clr_cnt`=1.
- Latency: a handshake in cycle N produces `Reg_Write`=1 with the captured addr/data in cycle N+1. The register file commits at the edge ending cycle N+1.
- Throughput: one write per cycle. `Reg_Write` deasserts in any cycle that follows a cycle without a handshake or clear write.
- Clear sequence duration:
  - The first rising edge after `rst` falls drives a write to register 1; the 31st edge drives a write to register 31.
  - `busy` falls after the 31st edge, and `req_ready` may assert in that same cycle.
  - The full sequence occupies 31 cycles.
- Reset mid-clear or mid-arbitration: outputs go to their reset values immediately (asynchronous). The clear sequence restarts from register 1.
- Simultaneous `clear_start` and valid requests in ARB: clear wins. Requests stay pending and are served after the clear completes, in round-robin order from the unchanged `rr_ptr`.

## Structure
- Shared package `regfile_ctrl_pkg` holds:
  - the FSM state enum (CLEAR, ARB);
  - `REG_COUNT`=32;
  - `ZERO_REG`=0;
  - `LAST_REG`=31.
- One sub-module, `rr_arbiter`, with parameter `NUM_REQ`.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `grant` and binary `grant_idx`.
  - Purely combinational.
- The top level holds the FSM, the counter, `rr_ptr`, the output registers and the request mux.

## Test plan
- Release `rst` and run 31 cycles → `Reg_Write`=1 with `Data`=0 on addresses 1…31 in order; `busy` falls after the 31st edge; no write to address 0.
- All 3 requesters valid continuously with distinct addresses 5/6/7 → grants rotate 0,1,2,0,…; one write per cycle, each with 1-cycle latency.
- Requester 1 alone writes addr 0, data 0xDEADBEEF → `req_ready[1]`=1; next cycle `Reg_Write`=0; `rr_ptr` becomes 2.
- `clear_start` asserted together with `req_valid[0]` → no grant that cycle; 31 clear writes follow; then requester 0 is granted with its held data.
- Assert `rst` at clear write to addr 12 → outputs are zero immediately; the sequence restarts at addr 1.
- Requester 2 holds valid while others are idle, then 0 and 2 are both valid after a grant to 2 → requester 0 is granted next.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared types and constants for the register file write path
package regfile_ctrl_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } wr_state_t;

  localparam int REG_COUNT = 32;
  localparam int ZERO_REG  = 0;
  localparam int LAST_REG  = REG_COUNT - 1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Grants the first asserted request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int idx;

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin owner of the register file write port
// Runs a zeroing sweep of registers 1..31 after reset or on clear_start, then arbitrates.
module regfile_write_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clear_start,
  output logic                      busy,
  output logic                      Reg_Write,
  output logic [ADDR_W-1:0]         Write_Register,
  output logic [DATA_W-1:0]         Data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wr_state_t          state, state_next;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               handshake;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A clear request suppresses the grant in the same cycle, so no write is lost.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      CLEAR: begin
        if (clr_cnt == ADDR_W'(LAST_REG)) state_next = ARB;
      end
      ARB: begin
        if (clear_start) state_next = CLEAR;
        else             req_ready  = grant;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign handshake = |(req_valid & req_ready);
  assign busy      = (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= CLEAR;
      clr_cnt        <= ADDR_W'(1);
      rr_ptr         <= '0;
      Reg_Write      <= 1'b0;
      Write_Register <= '0;
      Data           <= '0;
    end else begin
      state     <= state_next;
      Reg_Write <= 1'b0;
      if (state == CLEAR) begin
        Reg_Write      <= 1'b1;
        Write_Register <= clr_cnt;
        Data           <= '0;
        clr_cnt        <= clr_cnt + ADDR_W'(1);
      end else begin
        clr_cnt <= ADDR_W'(1);
        if (handshake) begin
          // Register 0 is hardwired to zero: consume the request but drop the write.
          Reg_Write      <= (sel_addr != ADDR_W'(ZERO_REG));
          Write_Register <= sel_addr;
          Data           <= sel_data;
          rr_ptr         <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             clear_start = 1'b0;
  logic             busy;
  logic             Reg_Write;
  logic [AW-1:0]    Write_Register;
  logic [DW-1:0]    Data;

  logic [AW-1:0] r_addr [NR];
  logic [DW-1:0] r_data [NR];

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_en  = 0;

  // reference model state
  bit m_arb;
  int m_cnt;
  int m_ptr;

  regfile_write_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .clear_start    (clear_start),
    .busy           (busy),
    .Reg_Write      (Reg_Write),
    .Write_Register (Write_Register),
    .Data           (Data)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = r_addr[i];
      req_data[i*DW +: DW] = r_data[i];
    end
  end

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: Reg_Write=%0b addr=%0d with no expected entry", Reg_Write, Write_Register);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.we) begin
          if (Reg_Write !== 1'b1 || Write_Register !== e.a || Data !== e.d) begin
            n_fail++;
            $display("FAIL write_port: got we=%0b addr=%0d data=%h, expected we=1 addr=%0d data=%h",
                     Reg_Write, Write_Register, Data, e.a, e.d);
          end
        end else if (Reg_Write !== 1'b0) begin
          n_fail++;
          $display("FAIL write_idle: got Reg_Write=%0b addr=%0d, expected Reg_Write=0", Reg_Write, Write_Register);
        end
      end
    end
  end

  function automatic int pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_arb = 0;
    m_cnt = 1;
    m_ptr = 0;
    exp_q.delete();
  endtask

  // One cycle: drive at negedge, check grant, advance model, push expected write.
  task automatic step(input logic [NR-1:0] v, input logic clr);
    int            g;
    logic [NR-1:0] eg;
    wr_t           e;
    req_valid   = v;
    clear_start = clr;
    #1;
    g  = -1;
    eg = '0;
    if (m_arb && !clr) begin
      g = pick(v, m_ptr);
      if (g >= 0) eg[g] = 1'b1;
    end
    n_tests++;
    if (req_ready !== eg) begin
      n_fail++;
      $display("FAIL req_ready: got %b, expected %b", req_ready, eg);
    end
    n_tests++;
    if (busy !== !m_arb) begin
      n_fail++;
      $display("FAIL busy: got %b, expected %b", busy, !m_arb);
    end
    e.we = 1'b0;
    e.a  = '0;
    e.d  = '0;
    if (!m_arb) begin
      e.we = 1'b1;
      e.a  = AW'(m_cnt);
      if (m_cnt == 31) m_arb = 1;
      m_cnt++;
    end else if (clr) begin
      m_arb = 0;
      m_cnt = 1;
    end else if (g >= 0) begin
      e.we  = (r_addr[g] != '0);
      e.a   = r_addr[g];
      e.d   = r_data[g];
      m_ptr = (g + 1) % NR;
    end
    exp_q.push_back(e);
    @(negedge clk);
    if (g >= 0) r_data[g] = $urandom;
  endtask

  task automatic test_reset();
    req_valid = 3'b111;
    repeat (2) @(negedge clk);
    n_tests++;
    if (Reg_Write !== 1'b0 || Write_Register !== '0 || Data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%0b addr=%0d data=%h, expected 0/0/0", Reg_Write, Write_Register, Data);
    end
    n_tests++;
    if (busy !== 1'b1 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_status: got busy=%b ready=%b, expected busy=1 ready=000", busy, req_ready);
    end
    req_valid = '0;
    model_reset();
    rst    = 1'b0;
    mon_en = 1;
  endtask

  task automatic test_clear_seq();
    repeat (31) step('0, 1'b0);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_done_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_rotate();
    for (int i = 0; i < NR; i++) begin
      r_addr[i] = AW'(5 + i);
      r_data[i] = $urandom;
    end
    repeat (9) step(3'b111, 1'b0);
    step('0, 1'b0);
  endtask

  task automatic test_zero_write();
    r_addr[1] = '0;
    r_data[1] = 32'hDEADBEEF;
    step(3'b010, 1'b0);
    r_addr[1] = AW'(9);
    r_addr[2] = AW'(10);
    step(3'b110, 1'b0);
    step('0, 1'b0);
  endtask

  task automatic test_fairness();
    r_addr[0] = AW'(3);
    r_addr[2] = AW'(20);
    step(3'b100, 1'b0);
    step(3'b101, 1'b0);
    step('0, 1'b0);
  endtask

  task automatic test_clear_with_req();
    r_addr[0] = AW'(17);
    r_data[0] = 32'h1234_5678;
    step(3'b001, 1'b1);
    for (int i = 0; i < 31; i++) step(3'b001, (i == 4 || i == 30));
    step(3'b001, 1'b0);
    step('0, 1'b0);
  endtask

  task automatic test_reset_mid();
    step('0, 1'b1);
    repeat (12) step('0, 1'b0);
    mon_en = 0;
    rst    = 1'b1;
    #1;
    n_tests++;
    if (Reg_Write !== 1'b0 || Write_Register !== '0 || Data !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got we=%0b addr=%0d data=%h busy=%b, expected 0/0/0/1",
               Reg_Write, Write_Register, Data, busy);
    end
    @(negedge clk);
    model_reset();
    rst    = 1'b0;
    mon_en = 1;
    repeat (31) step('0, 1'b0);
    step(3'b011, 1'b0);
    step('0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      r_addr[i] = '0;
      r_data[i] = '0;
    end
    model_reset();
    test_reset();
    test_clear_seq();
    test_rotate();
    test_zero_write();
    test_fairness();
    test_clear_with_req();
    test_reset_mid();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d writes outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
